// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - command/response bundle between the MEM-stage controller and the data memory responder
interface data_mem_responder_if;
    logic [31:0] Address;
    logic [31:0] MWriteData;
    logic [3:0]  WriteEnable;
    logic        ReadEnable;
    logic [31:0] MReadData;
    logic        DataMem_Ready;
    logic        Busy;
    logic        Protocol_Error;

    modport master (
        output Address,
        output MWriteData,
        output WriteEnable,
        output ReadEnable,
        input  MReadData,
        input  DataMem_Ready,
        input  Busy,
        input  Protocol_Error
    );

    modport slave (
        input  Address,
        input  MWriteData,
        input  WriteEnable,
        input  ReadEnable,
        output MReadData,
        output DataMem_Ready,
        output Busy,
        output Protocol_Error
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated word-addressed data SRAM responder with byte-lane writes
module data_mem_responder #(
    parameter int ADDR_WIDTH    = 10,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    data_mem_responder_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP,
        S_HOLD
    } state_t;

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic                    accept;
    logic                    req;
    logic                    req_is_wr;
    logic [3:0]              req_lat;

    logic [ADDR_WIDTH-1:0]   word_q;
    logic [31:0]             wdata_q;
    logic [3:0]              we_q;
    logic                    is_wr_q;
    logic [31:0]             rdata_q;
    logic                    ready_q;
    logic                    perr_q;

    logic [31:0]             mem [0:DEPTH-1];

    // Address bits above the word index alias and the byte offset is implied by the strobes.
    wire unused_addr_bits = ^{bus.Address[31:ADDR_WIDTH+2], bus.Address[1:0]};

    assign req       = bus.ReadEnable | (bus.WriteEnable != 4'h0);
    assign req_is_wr = (bus.WriteEnable != 4'h0);
    assign req_lat   = req_is_wr ? WR_LAT : RD_LAT;

    // Next-state and counter logic; a write strobe wins over a simultaneous read.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (req_lat != 4'd0) begin
                        state_n = S_WAIT;
                        cnt_n   = req_lat;
                    end else begin
                        state_n = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_n = S_ACCESS;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_ACCESS: state_n = S_RESP;
            S_RESP:   state_n = S_HOLD;
            S_HOLD:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // State register, request capture, read data, Ready pulse and sticky error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            word_q  <= '0;
            wdata_q <= 32'h0;
            we_q    <= 4'h0;
            is_wr_q <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ready_q <= (state_n == S_RESP);
            if (accept) begin
                word_q  <= bus.Address[ADDR_WIDTH+1:2];
                wdata_q <= bus.MWriteData;
                we_q    <= bus.WriteEnable;
                is_wr_q <= req_is_wr;
                if (req_is_wr && bus.ReadEnable) begin
                    perr_q <= 1'b1;
                end
            end
            if (state == S_ACCESS && !is_wr_q) begin
                rdata_q <= mem[word_q];
            end
        end
    end

    // Byte-lane array update on the ACCESS edge; the array is deliberately not reset.
    always_ff @(posedge clock) begin
        if (state == S_ACCESS && is_wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (we_q[b]) begin
                    mem[word_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign bus.MReadData      = rdata_q;
    assign bus.DataMem_Ready  = ready_q;
    assign bus.Busy           = (state != S_IDLE);
    assign bus.Protocol_Error = perr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized scoreboard bench for data_mem_responder
module tb_data_mem_responder;

    localparam int M_RL = 2;
    localparam int M_WL = 1;
    localparam int Z_RL = 0;
    localparam int Z_WL = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_we = 4'h0;
    logic        d_re = 1'b0;
    int          cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    data_mem_responder_if mbus();
    data_mem_responder_if zbus();

    assign mbus.Address     = d_addr;
    assign mbus.MWriteData  = d_wdata;
    assign mbus.WriteEnable = sel ? 4'h0 : d_we;
    assign mbus.ReadEnable  = !sel && d_re;
    assign zbus.Address     = d_addr;
    assign zbus.MWriteData  = d_wdata;
    assign zbus.WriteEnable = sel ? d_we : 4'h0;
    assign zbus.ReadEnable  = sel && d_re;

    data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(M_RL), .WRITE_LATENCY(M_WL))
        dut_m (.clock(clock), .reset_n(reset_n), .bus(mbus.slave));
    data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(Z_RL), .WRITE_LATENCY(Z_WL))
        dut_z (.clock(clock), .reset_n(reset_n), .bus(zbus.slave));

    wire        rdy   = sel ? zbus.DataMem_Ready  : mbus.DataMem_Ready;
    wire        busy  = sel ? zbus.Busy           : mbus.Busy;
    wire [31:0] rdata = sel ? zbus.MReadData      : mbus.MReadData;
    wire        perr  = sel ? zbus.Protocol_Error : mbus.Protocol_Error;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        int          exp_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          checks = 0;
    int          errors = 0;
    int          last_rdy = 0;
    int          prev_rdy = 0;

    logic [31:0] mm [2][1024];
    logic [31:0] km [2][1024];
    logic [31:0] last_rd [2];
    logic [31:0] last_mk [2];
    logic        perr_m [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every Ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got Ready=1 expected no response (cyc=%0d)", cyc);
            end else begin
                me = sb.pop_front();
                check("ready_cycle", cyc, me.exp_cyc);
                check("rdata", rdata & me.mask, me.data & me.mask);
                prev_rdy = last_rdy;
                last_rdy = cyc;
            end
        end
    end

    // Issue one command at a negedge. mode 0: hold until Ready, 1: drop after one cycle,
    // 2: hold through the HOLD cycle.
    task automatic issue(input logic [31:0] a, input logic [3:0] we, input logic re,
                         input logic [31:0] wd, input int mode);
        int   w, lat, busy_n, guard;
        logic is_wr;
        exp_t e;
        int   s;
        s = sel ? 1 : 0;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (busy) begin
            check("idle_timeout", 32'(busy), 32'h0);
            return;
        end
        is_wr = (we != 4'h0);
        w = int'(a[11:2]);
        lat = is_wr ? (sel ? Z_WL : M_WL) : (sel ? Z_RL : M_RL);
        if (is_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mm[s][w][8*b +: 8] = wd[8*b +: 8];
                    km[s][w] = km[s][w] | (32'hFF << (8*b));
                end
            end
            if (re) perr_m[s] = 1'b1;
        end else begin
            last_rd[s] = mm[s][w];
            last_mk[s] = km[s][w];
        end
        e.data = last_rd[s];
        e.mask = last_mk[s];
        e.exp_cyc = cyc + 2 + lat;
        sb.push_back(e);
        d_addr = a; d_we = we; d_re = re; d_wdata = wd;
        busy_n = 0;
        guard = 0;
        @(negedge clock);
        while (busy && guard < 100) begin
            busy_n++;
            if (mode == 1 || (mode == 0 && rdy)) begin
                d_we = 4'h0; d_re = 1'b0;
            end
            @(negedge clock);
            guard++;
        end
        d_we = 4'h0; d_re = 1'b0;
        check("busy_cycles", busy_n, lat + 3);
        check("protocol_error", 32'(perr), 32'(perr_m[s]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, wd;
        logic [3:0]  we;
        logic        re;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 1024; i++) begin
                mm[s][i] = 32'h0;
                km[s][i] = 32'h0;
            end
            last_rd[s] = 32'h0;
            last_mk[s] = 32'hFFFF_FFFF;
            perr_m[s] = 1'b0;
        end

        repeat (2) @(negedge clock);
        check("reset_ready", 32'(mbus.DataMem_Ready), 32'h0);
        check("reset_busy", 32'(mbus.Busy), 32'h0);
        check("reset_rdata", mbus.MReadData, 32'h0);
        check("reset_perr", 32'(mbus.Protocol_Error), 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // Reset in the middle of a write's WAIT state.
        issue(32'h10, 4'hF, 1'b0, 32'h0102_0304, 0);
        d_addr = 32'h10; d_we = 4'hF; d_wdata = 32'hDEAD_BEEF; d_re = 1'b0;
        @(negedge clock);
        check("pre_reset_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        d_we = 4'h0;
        repeat (2) @(negedge clock);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_rdata", rdata, 32'h0);
        reset_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            last_rd[s] = 32'h0; last_mk[s] = 32'hFFFF_FFFF; perr_m[s] = 1'b0;
        end
        repeat (3) @(negedge clock);
        check("postreset_busy", 32'(busy), 32'h0);
        issue(32'h10, 4'h0, 1'b1, 32'h0, 0);

        // Full word, byte lanes, conflict, early drop, alias.
        issue(32'h40, 4'hF, 1'b0, 32'hCAFE_BABE, 0);
        issue(32'h40, 4'h0, 1'b1, 32'h0, 0);
        issue(32'h80, 4'hF, 1'b0, 32'h1122_3344, 0);
        issue(32'h80, 4'b0100, 1'b0, 32'h00AA_0000, 0);
        issue(32'h80, 4'h0, 1'b1, 32'h0, 0);
        issue(32'h80, 4'b0011, 1'b0, 32'h0000_5566, 0);
        issue(32'h80, 4'h0, 1'b1, 32'h0, 1);
        issue(32'h84, 4'hF, 1'b1, 32'h1234_5678, 0);
        issue(32'h84, 4'h0, 1'b1, 32'h0, 1);
        issue(32'h1000, 4'hF, 1'b0, 32'h5A5A_0F0F, 0);
        issue(32'h0000, 4'h0, 1'b1, 32'h0, 2);

        // Back-to-back reads, each holding its enables through HOLD.
        issue(32'h40, 4'h0, 1'b1, 32'h0, 2);
        issue(32'h80, 4'h0, 1'b1, 32'h0, 2);
        check("ready_gap", last_rdy - prev_rdy - 1, M_RL + 3);

        // Randomized traffic over a small aliased window.
        for (int n = 0; n < 40; n++) begin
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            wd = $urandom;
            we = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            re = (we == 4'h0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            issue(a, we, re, wd, int'($urandom_range(0, 2)));
        end

        // Zero read latency instance.
        @(negedge clock);
        sel = 1'b1;
        @(negedge clock);
        issue(32'h20, 4'hF, 1'b0, 32'hA1B2_C3D4, 0);
        issue(32'h20, 4'h0, 1'b1, 32'h0, 0);
        issue(32'h20, 4'h0, 1'b1, 32'h0, 1);
        for (int n = 0; n < 12; n++) begin
            a  = 32'($urandom_range(0, 7)) << 2;
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            issue(a, we, (we == 4'h0), $urandom, int'($urandom_range(0, 2)));
        end

        repeat (5) @(negedge clock);
        check("scoreboard_empty", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
